// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use bubbles, branch flushes and data-memory wait stalls with timeout.
// Optional performance counters are enabled with the HAZARD_PERF_CNT_EN macro.
module hazard_unit #(
    parameter int unsigned MEM_TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rs1_adr,
    input  logic [4:0]  rs2_adr,
    input  logic        rs1_used,
    input  logic        rs2_used,
    input  logic        D_E_mem_rd,
    input  logic [4:0]  D_E_rd_adr,
    input  logic        branch_taken,
    input  logic        E_M_mem_req,
    input  logic        dmem_ack,
    output logic        stall_F,
    output logic        stall_D,
    output logic        stall_E,
    output logic        stall_M,
    output logic        flush_D,
    output logic        flush_E,
    output logic        mem_err
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN,
        LOAD_BUB,
        MEM_WAIT,
        FLUSH_WAIT
    } state_t;

    localparam logic [15:0] TIMEOUT_VAL = 16'(MEM_TIMEOUT);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;

    logic load_use;
    logic mem_wait;
    logic stall_f_c, stall_d_c, stall_e_c, stall_m_c;
    logic flush_d_c, flush_e_c, mem_err_c;
    logic branch_flush;

    // x0 is hard-wired to zero, so a load targeting it never creates a dependency.
    assign load_use = D_E_mem_rd && (D_E_rd_adr != 5'd0) &&
                      ((rs1_used && (rs1_adr == D_E_rd_adr)) ||
                       (rs2_used && (rs2_adr == D_E_rd_adr)));
    assign mem_wait = E_M_mem_req && !dmem_ack;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        stall_f_c    = 1'b0;
        stall_d_c    = 1'b0;
        stall_e_c    = 1'b0;
        stall_m_c    = 1'b0;
        flush_d_c    = 1'b0;
        flush_e_c    = 1'b0;
        mem_err_c    = 1'b0;
        branch_flush = 1'b0;
        case (state_q)
            RUN, LOAD_BUB: begin
                state_d = RUN;
                if (mem_wait) begin
                    stall_f_c = 1'b1;
                    stall_d_c = 1'b1;
                    stall_e_c = 1'b1;
                    stall_m_c = 1'b1;
                    cnt_d     = 16'd0;
                    state_d   = MEM_WAIT;
                end else if (branch_taken) begin
                    flush_d_c    = 1'b1;
                    flush_e_c    = 1'b1;
                    branch_flush = 1'b1;
                end else if (load_use && (state_q == RUN)) begin
                    stall_f_c = 1'b1;
                    stall_d_c = 1'b1;
                    flush_e_c = 1'b1;
                    state_d   = LOAD_BUB;
                end
            end
            MEM_WAIT: begin
                if (dmem_ack) begin
                    // A branch resolved during the wait is flushed once the pipe moves again.
                    state_d = branch_taken ? FLUSH_WAIT : RUN;
                end else if (cnt_q == TIMEOUT_VAL) begin
                    mem_err_c = 1'b1;
                    state_d   = RUN;
                end else begin
                    stall_f_c = 1'b1;
                    stall_d_c = 1'b1;
                    stall_e_c = 1'b1;
                    stall_m_c = 1'b1;
                    cnt_d     = cnt_q + 16'd1;
                end
            end
            FLUSH_WAIT: begin
                flush_d_c    = 1'b1;
                flush_e_c    = 1'b1;
                branch_flush = 1'b1;
                state_d      = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are qualified by reset so nothing leaks while rst_n is low.
    assign stall_F = rst_n & stall_f_c;
    assign stall_D = rst_n & stall_d_c;
    assign stall_E = rst_n & stall_e_c;
    assign stall_M = rst_n & stall_m_c;
    assign flush_D = rst_n & flush_d_c;
    assign flush_E = rst_n & flush_e_c;
    assign mem_err = rst_n & mem_err_c;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_f_c) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (branch_flush) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit; outputs are compared as the vector
// {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, mem_err}.
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs1_adr, rs2_adr, D_E_rd_adr;
    logic       rs1_used, rs2_used, D_E_mem_rd, branch_taken, E_M_mem_req, dmem_ack;
    logic       stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, mem_err;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif
    logic [6:0] outs;
    int n_checks = 0;
    int n_fail = 0;

    localparam logic [6:0] IDLE  = 7'b0000000;
    localparam logic [6:0] LU    = 7'b1100010;
    localparam logic [6:0] MEMST = 7'b1111000;
    localparam logic [6:0] BRFL  = 7'b0000110;
    localparam logic [6:0] ERR   = 7'b0000001;

    hazard_unit #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_adr(rs1_adr), .rs2_adr(rs2_adr), .rs1_used(rs1_used), .rs2_used(rs2_used),
        .D_E_mem_rd(D_E_mem_rd), .D_E_rd_adr(D_E_rd_adr), .branch_taken(branch_taken),
        .E_M_mem_req(E_M_mem_req), .dmem_ack(dmem_ack),
        .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
        .flush_D(flush_D), .flush_E(flush_E), .mem_err(mem_err)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;
    assign outs = {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, mem_err};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2,
                          input logic ld, input logic [4:0] rd, input logic br,
                          input logic req, input logic ack);
        rs1_adr = r1; rs1_used = u1; rs2_adr = r2; rs2_used = u2;
        D_E_mem_rd = ld; D_E_rd_adr = rd; branch_taken = br;
        E_M_mem_req = req; dmem_ack = ack;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_in(5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
        n_checks++; if (outs !== IDLE) begin n_fail++; $display("FAIL reset_out: got %b expected %b", outs, IDLE); end
        tick();
        n_checks++; if (outs !== IDLE) begin n_fail++; $display("FAIL reset_hold: got %b expected %b", outs, IDLE); end
        set_in(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1;
        n_checks++; if (outs !== IDLE) begin n_fail++; $display("FAIL reset_release: got %b expected %b", outs, IDLE); end
        tick();
        $display("test_reset done");
    endtask

    task automatic test_load_use();
        set_in(5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        n_checks++; if (outs !== LU) begin n_fail++; $display("FAIL lu_stall: got %b expected %b", outs, LU); end
        tick();
        n_checks++; if (outs !== IDLE) begin n_fail++; $display("FAIL lu_bubble: got %b expected %b", outs, IDLE); end
        tick();
        n_checks++; if (outs !== LU) begin n_fail++; $display("FAIL lu_again: got %b expected %b", outs, LU); end
        tick();
        set_in(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        n_checks++; if (outs !== LU) begin n_fail++; $display("FAIL lu_rs2: got %b expected %b", outs, LU); end
        tick();
        set_in(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(5'd5, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        n_checks++; if (outs !== IDLE) begin n_fail++; $display("FAIL lu_rs1_unused: got %b expected %b", outs, IDLE); end
        set_in(5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0);
        n_checks++; if (outs !== IDLE) begin n_fail++; $display("FAIL lu_no_load: got %b expected %b", outs, IDLE); end
        set_in(5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0);
        n_checks++; if (outs !== IDLE) begin n_fail++; $display("FAIL lu_addr_diff: got %b expected %b", outs, IDLE); end
        set_in(5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        n_checks++; if (outs !== BRFL) begin n_fail++; $display("FAIL lu_bub_branch: got %b expected %b", outs, BRFL); end
        tick();
        set_in(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (outs !== IDLE) begin n_fail++; $display("FAIL lu_bub_exit: got %b expected %b", outs, IDLE); end
        tick();
        $display("test_load_use done");
    endtask

    task automatic test_x0();
        set_in(5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (outs !== IDLE) begin n_fail++; $display("FAIL x0_no_stall: got %b expected %b", outs, IDLE); end
        tick();
        n_checks++; if (outs !== IDLE) begin n_fail++; $display("FAIL x0_next: got %b expected %b", outs, IDLE); end
        set_in(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        $display("test_x0 done");
    endtask

    task automatic test_mem_wait();
        set_in(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        n_checks++; if (outs !== MEMST) begin n_fail++; $display("FAIL mw_enter: got %b expected %b", outs, MEMST); end
        tick();
        n_checks++; if (outs !== MEMST) begin n_fail++; $display("FAIL mw_cycle1: got %b expected %b", outs, MEMST); end
        tick();
        n_checks++; if (outs !== MEMST) begin n_fail++; $display("FAIL mw_cycle2: got %b expected %b", outs, MEMST); end
        tick();
        set_in(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        n_checks++; if (outs !== IDLE) begin n_fail++; $display("FAIL mw_ack: got %b expected %b", outs, IDLE); end
        tick();
        set_in(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (outs !== IDLE) begin n_fail++; $display("FAIL mw_after_ack: got %b expected %b", outs, IDLE); end
        set_in(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        tick();
        set_in(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
        n_checks++; if (outs !== IDLE) begin n_fail++; $display("FAIL mw_ack_branch: got %b expected %b", outs, IDLE); end
        tick();
        set_in(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (outs !== BRFL) begin n_fail++; $display("FAIL flush_wait: got %b expected %b", outs, BRFL); end
        tick();
        n_checks++; if (outs !== IDLE) begin n_fail++; $display("FAIL after_flush_wait: got %b expected %b", outs, IDLE); end
        set_in(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        n_checks++; if (outs !== IDLE) begin n_fail++; $display("FAIL mem_same_cycle_ack: got %b expected %b", outs, IDLE); end
        tick();
        set_in(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        n_checks++; if (outs !== MEMST) begin n_fail++; $display("FAIL mem_after_same_ack: got %b expected %b", outs, MEMST); end
        tick();
        set_in(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        tick();
        set_in(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        $display("test_mem_wait done");
    endtask

    task automatic test_priority();
        set_in(5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
        n_checks++; if (outs !== MEMST) begin n_fail++; $display("FAIL prio_mem_over_branch: got %b expected %b", outs, MEMST); end
        tick();
        set_in(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        tick();
        set_in(5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        n_checks++; if (outs !== BRFL) begin n_fail++; $display("FAIL prio_branch_over_lu: got %b expected %b", outs, BRFL); end
        tick();
        n_checks++; if (outs !== BRFL) begin n_fail++; $display("FAIL prio_branch_stay_run: got %b expected %b", outs, BRFL); end
        set_in(5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        n_checks++; if (outs !== LU) begin n_fail++; $display("FAIL prio_lu_after_branch: got %b expected %b", outs, LU); end
        tick();
        set_in(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        $display("test_priority done");
    endtask

    task automatic test_timeout();
        set_in(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        n_checks++; if (outs !== MEMST) begin n_fail++; $display("FAIL to_enter: got %b expected %b", outs, MEMST); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (outs !== MEMST) begin n_fail++; $display("FAIL to_wait%0d: got %b expected %b", i, outs, MEMST); end
        end
        tick();
        n_checks++; if (outs !== ERR) begin n_fail++; $display("FAIL to_err: got %b expected %b", outs, ERR); end
        tick();
        set_in(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (outs !== IDLE) begin n_fail++; $display("FAIL to_back_run: got %b expected %b", outs, IDLE); end
        tick();
        n_checks++; if (outs !== IDLE) begin n_fail++; $display("FAIL to_err_once: got %b expected %b", outs, IDLE); end
        $display("test_timeout done");
    endtask

    task automatic test_reset_mid_wait();
        set_in(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        tick();
        n_checks++; if (outs !== MEMST) begin n_fail++; $display("FAIL rmw_in_wait: got %b expected %b", outs, MEMST); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (outs !== IDLE) begin n_fail++; $display("FAIL rmw_async: got %b expected %b", outs, IDLE); end
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++; if (outs !== IDLE) begin n_fail++; $display("FAIL rmw_hold%0d: got %b expected %b", i, outs, IDLE); end
        end
        set_in(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1;
        n_checks++; if (outs !== IDLE) begin n_fail++; $display("FAIL rmw_release: got %b expected %b", outs, IDLE); end
        set_in(5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
        n_checks++; if (outs !== LU) begin n_fail++; $display("FAIL rmw_state_run: got %b expected %b", outs, LU); end
        tick();
        set_in(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        $display("test_reset_mid_wait done");
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_x0();
        test_mem_wait();
        test_priority();
        test_timeout();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 1023: maximum MEM_WAIT cycles before abort; legal range 1..65535.
REQ-002 SHALL have port clk, input, 1: the single clock, rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have ports rs1_adr and rs2_adr, input, 5 each: decode-stage source register addresses.
REQ-005 SHALL have ports rs1_used and rs2_used, input, 1 each: the decode-stage instruction reads that source.
REQ-006 SHALL have ports D_E_mem_rd, input, 1, and D_E_rd_adr, input, 5: a load is in execute, and its destination register.
REQ-007 SHALL have port branch_taken, input, 1: execute-stage branch or jump redirects the PC.
REQ-008 SHALL have ports E_M_mem_req, input, 1, and dmem_ack, input, 1: a memory access is in the memory stage, and its completion.
REQ-009 SHALL have ports stall_F, stall_D, stall_E and stall_M, output, 1 each: hold the corresponding pipeline register.
REQ-010 SHALL have ports flush_D and flush_E, output, 1 each: load a bubble into the decode or execute register.
REQ-011 SHALL have port mem_err, output, 1: one-cycle pulse on memory timeout.

Function
REQ-012 SHALL implement the states RUN, LOAD_BUB, MEM_WAIT and FLUSH_WAIT in a registered FSM; all outputs SHALL be combinational from state and inputs, with zero latency.
REQ-013 SHALL detect load-use as D_E_mem_rd=1, D_E_rd_adr!=0, and (rs1_used and rs1_adr==D_E_rd_adr) or (rs2_used and rs2_adr==D_E_rd_adr).
REQ-014 Priority SHALL be memory wait, then branch_taken, then load-use.
REQ-015 In RUN, when E_M_mem_req=1 and dmem_ack=0: assert stall_F, stall_D, stall_E and stall_M with no flush; go to MEM_WAIT; clear the timeout counter.
REQ-016 In RUN, when E_M_mem_req=1 and dmem_ack=1 in the same cycle: no stall and stay in RUN.
REQ-017 In MEM_WAIT, all four stalls SHALL stay high until dmem_ack=1; in the ack cycle all stalls are low.
REQ-018 MEM_WAIT exit on ack SHALL go to FLUSH_WAIT if branch_taken=1, else to RUN.
REQ-019 In FLUSH_WAIT: assert flush_D and flush_E for one cycle with no stalls, then go to RUN.
REQ-020 The MEM_WAIT counter SHALL increment each cycle; when it reaches MEM_TIMEOUT with no ack, pulse mem_err, drop the stalls and go to RUN.
REQ-021 In RUN, with no memory wait and branch_taken=1: assert flush_D and flush_E that cycle and stay in RUN; a simultaneous load-use SHALL be ignored.
REQ-022 In RUN, on load-use only: assert stall_F, stall_D and flush_E for one cycle and go to LOAD_BUB.
REQ-023 In LOAD_BUB, load-use detection SHALL be suppressed for one cycle; memory wait and branch SHALL be evaluated as in RUN; otherwise return to RUN.
REQ-024 Registers x0 SHALL never cause a stall.

Reset
REQ-025 rst_n=0 SHALL asynchronously force state RUN, clear the timeout counter and clear the perf counters.
REQ-026 During reset, all stall and flush outputs and mem_err SHALL be 0.
REQ-027 Reset asserted mid-MEM_WAIT SHALL abandon the wait without asserting mem_err.

Configuration
REQ-028 With macro HAZARD_PERF_CNT_EN defined, the unit SHALL add outputs stall_cnt and flush_cnt (32 bits each, wrap-around).
REQ-029 Under HAZARD_PERF_CNT_EN, stall_cnt SHALL increment on any cycle with stall_F=1, and flush_cnt SHALL increment on any cycle with flush_E=1 caused by branch.
REQ-030 Without HAZARD_PERF_CNT_EN, those ports and registers SHALL be absent, and behaviour is otherwise identical.

Verification
REQ-031 Load x5 in E; decode uses rs1=5 -> stall_F=stall_D=flush_E=1 for exactly 1 cycle, then LOAD_BUB, then RUN.
REQ-032 Load x0 in E; decode rs1=0 -> no stall.
REQ-033 E_M_mem_req=1, dmem_ack delayed 3 cycles -> 3 cycles of all stalls, low in the ack cycle.
REQ-034 branch_taken=1 together with load-use -> flush_D=flush_E=1, stall_F=0, stays in RUN.
REQ-035 MEM_TIMEOUT=4, ack never arrives -> mem_err pulses once after 4 MEM_WAIT cycles, then RUN.
REQ-036 rst_n low during MEM_WAIT -> outputs 0 immediately, state RUN, mem_err stays 0.
